// File: rtl/adc_led_meter_if.sv
// ADC sample / debug LED bundle for adc_led_meter.
// master drives the ADC samples; slave (the meter) drives the LEDs.
interface adc_led_meter_if;
  logic [11:0] adc_data;
  logic        adc_otr;
  logic        adc_valid;
  logic        led_ok;
  logic [2:0]  led_bar;
  logic [10:0] peak_mag;
  logic        window_done;

  modport master (
    output adc_data, adc_otr, adc_valid,
    input  led_ok, led_bar, peak_mag, window_done
  );

  modport slave (
    input  adc_data, adc_otr, adc_valid,
    output led_ok, led_bar, peak_mag, window_done
  );
endinterface

// File: rtl/adc_led_meter.sv
// adc_led_meter: windowed peak bar LEDs and stretched overrange LED.
// Define ADC_LED_PEAKHOLD_EN to drive the bar from a decaying hold.
module adc_led_meter #(
  parameter int WINDOW_LEN  = 4096,
  parameter int OTR_HOLD    = 4800000,
  parameter int LAMP_CYCLES = 24000000,
  parameter int TH1         = 256,
  parameter int TH2         = 512,
  parameter int TH3         = 1024
) (
  input logic            clk,
  input logic            rst,
  adc_led_meter_if.slave bus
);

  localparam int LW = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;
  localparam int HW = (OTR_HOLD > 1) ? $clog2(OTR_HOLD) : 1;
  localparam int WW = $clog2(WINDOW_LEN);

  typedef enum logic {
    LAMP,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          in_lamp;
  logic          in_run;
  logic [LW-1:0] lamp_cnt;
  logic          lamp_done;

  logic          sample_ok;
  logic          otr_load;
  logic [10:0]   mag;
  logic [10:0]   mag_q;
  logic          mag_v;
  logic          last_q;
  logic [WW-1:0] win_cnt;
  logic          win_last;
  logic [10:0]   acc;
  logic [10:0]   win_max;
  logic          close;
  logic [10:0]   peak_q;
  logic          done_q;
  logic [10:0]   bar_src;
  logic [HW-1:0] hold_cnt;
  logic          led_ok_q;
  logic [2:0]    led_bar_q;

  function automatic logic [2:0] thermo(input logic [10:0] v);
    thermo = {v >= 11'(TH3), v >= 11'(TH2), v >= 11'(TH1)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LAMP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LAMP:    if (lamp_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = LAMP;
    endcase
  end

  always_comb begin
    in_lamp = 1'b0;
    in_run  = 1'b0;
    unique case (state_q)
      LAMP:    in_lamp = 1'b1;
      RUN:     in_run  = 1'b1;
      default: in_lamp = 1'b1;
    endcase
  end

  assign lamp_done = lamp_cnt == LW'(LAMP_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lamp_cnt <= '0;
    else if (in_lamp && !lamp_done)
      lamp_cnt <= lamp_cnt + 1'b1;
  end

  assign sample_ok = in_run && bus.adc_valid;
  assign otr_load  = sample_ok && bus.adc_otr;
  assign win_last  = win_cnt == WW'(WINDOW_LEN - 1);

  // |x| of a negative value is 2048 - x[10:0]; x = -2048 saturates.
  always_comb begin
    mag = bus.adc_data[10:0];
    if (bus.adc_data[11])
      mag = (bus.adc_data[10:0] == '0) ? 11'h7ff
                                       : ~bus.adc_data[10:0] + 11'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q   <= '0;
      mag_v   <= 1'b0;
      last_q  <= 1'b0;
      win_cnt <= '0;
    end else begin
      mag_v  <= sample_ok;
      last_q <= sample_ok && win_last;
      if (sample_ok) begin
        mag_q   <= mag;
        win_cnt <= win_last ? '0 : win_cnt + 1'b1;
      end
    end
  end

  assign win_max = (mag_q > acc) ? mag_q : acc;
  assign close   = mag_v && last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      peak_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= close;
      if (close) begin
        peak_q <= win_max;
        acc    <= '0;
      end else if (mag_v) begin
        acc <= win_max;
      end
    end
  end

`ifdef ADC_LED_PEAKHOLD_EN
  logic [10:0] hold_q;
  logic [10:0] hold_dec;

  always_comb begin
    priority case (1'b1)
      hold_q >= 11'(TH3): hold_dec = 11'(TH2);
      hold_q >= 11'(TH2): hold_dec = 11'(TH1);
      default:            hold_dec = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_q <= '0;
    else if (close)
      hold_q <= (win_max > hold_dec) ? win_max : hold_dec;
  end

  assign bar_src = hold_q;
`else
  assign bar_src = peak_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt <= '0;
    else if (otr_load)
      hold_cnt <= HW'(OTR_HOLD - 1);
    else if (hold_cnt != '0)
      hold_cnt <= hold_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_ok_q  <= 1'b0;
      led_bar_q <= 3'b000;
    end else if (in_lamp) begin
      led_ok_q  <= 1'b1;
      led_bar_q <= 3'b111;
    end else begin
      led_ok_q  <= !(otr_load || hold_cnt != '0);
      led_bar_q <= thermo(bar_src);
    end
  end

  assign bus.led_ok      = led_ok_q;
  assign bus.led_bar     = led_bar_q;
  assign bus.peak_mag    = peak_q;
  assign bus.window_done = done_q;

endmodule

// File: tb/tb_adc_led_meter.sv
// tb_adc_led_meter: directed + random stimulus against a
// timestamped window/overrange reference model.
module tb_adc_led_meter;

  localparam int WL = 8;
  localparam int OH = 16;
  localparam int LC = 4;
  localparam int T1 = 256;
  localparam int T2 = 512;
  localparam int T3 = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_led_meter_if bus ();

  adc_led_meter #(
    .WINDOW_LEN (WL),
    .OTR_HOLD   (OH),
    .LAMP_CYCLES(LC),
    .TH1        (T1),
    .TH2        (T2),
    .TH3        (T3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int cyc;
  int done_at;
  int peak_at;
  int bar_at;
  int otr_last;
  int hold_lvl;
  int exp_peak;
  int pend_peak;
  int exp_lvl;
  int pend_lvl;
  int win[$];

  function automatic int lvl_of(input int m);
    if (m >= T3) return 3;
    if (m >= T2) return 2;
    if (m >= T1) return 1;
    return 0;
  endfunction

  function automatic int bar_of(input int l);
    return (1 << l) - 1;
  endfunction

  function automatic int mag_of(input logic [11:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs,
                     input int exp);
    n_chk++;
    assert (obs === 12'(exp)) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    win.delete();
    done_at   = -10;
    peak_at   = -10;
    bar_at    = -10;
    otr_last  = -100;
    hold_lvl  = 0;
    exp_peak  = 0;
    pend_peak = 0;
    exp_lvl   = 0;
    pend_lvl  = 0;
  endtask

  task automatic chk_reset();
    chk("rst_led_ok", 12'(bus.led_ok), 0);
    chk("rst_led_bar", 12'(bus.led_bar), 0);
    chk("rst_peak_mag", 12'(bus.peak_mag), 0);
    chk("rst_window_done", 12'(bus.window_done), 0);
  endtask

  task automatic check_all();
    if (cyc <= LC) begin
      chk("lamp_led_ok", 12'(bus.led_ok), 1);
      chk("lamp_led_bar", 12'(bus.led_bar), 7);
    end else begin
      chk("led_ok", 12'(bus.led_ok), (cyc <= otr_last) ? 0 : 1);
      chk("led_bar", 12'(bus.led_bar), bar_of(exp_lvl));
    end
    chk("window_done", 12'(bus.window_done),
        (cyc == done_at) ? 1 : 0);
    chk("peak_mag", 12'(bus.peak_mag), exp_peak);
  endtask

  task automatic step(input bit v, input int d, input bit o);
    int mx;
    bus.adc_valid = v;
    bus.adc_data  = 12'(d);
    bus.adc_otr   = o;
    @(posedge clk);
    cyc++;
    if (v && cyc > LC) begin
      win.push_back(mag_of(12'(d)));
      if (o) otr_last = cyc + OH - 1;
      if (win.size() == WL) begin
        mx = 0;
        foreach (win[i]) if (win[i] > mx) mx = win[i];
        win.delete();
        pend_peak = mx;
        done_at   = cyc + 1;
        peak_at   = cyc + 1;
        bar_at    = cyc + 2;
`ifdef ADC_LED_PEAKHOLD_EN
        hold_lvl  = (lvl_of(mx) > hold_lvl - 1) ? lvl_of(mx)
                                                : hold_lvl - 1;
        pend_lvl  = hold_lvl;
`else
        pend_lvl  = lvl_of(mx);
`endif
      end
    end
    if (cyc == peak_at) exp_peak = pend_peak;
    if (cyc == bar_at) exp_lvl = pend_lvl;
    #1;
    check_all();
  endtask

  task automatic window_of(input int p);
    step(1, p, 0);
    repeat (WL - 1) step(1, -(p / 2), 0);
    repeat (2) step(0, 0, 0);
  endtask

  initial begin
    int d;
    bit v;
    bit o;
    n_chk  = 0;
    n_fail = 0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    bus.adc_otr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;

    // lamp test; samples and overrange here must be ignored
    step(1, -2048, 1);
    step(1, 2047, 1);
    step(0, 0, 0);
    step(1, 1500, 1);
    step(0, 0, 0);

    step(1, 100, 0);
    step(1, -300, 0);
    step(1, 50, 0);
    step(1, 10, 0);
    step(1, -20, 0);
    step(1, 30, 0);
    step(1, 0, 0);
    step(1, -299, 0);
    repeat (3) step(0, 0, 0);

    step(1, -2048, 0);
    repeat (WL - 1) step(1, 5, 0);
    repeat (WL) step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    step(1, 0, 1);
    repeat (20) step(0, 0, 0);
    step(1, 0, 1);
    repeat (9) step(0, 0, 0);
    step(1, 0, 1);
    repeat (20) step(0, 0, 0);
    repeat (5) step(0, 0, 1);

    while (win.size() != 0) step(1, 0, 0);
    window_of(1500);
    window_of(100);
    window_of(100);
    window_of(100);

    for (int k = 0; k < 300; k++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       d = int'($urandom_range(0, 300));
        1:       d = -int'($urandom_range(0, 700));
        2:       d = int'($urandom_range(0, 4095)) - 2048;
        default: d = int'($urandom_range(900, 1100));
      endcase
      step(v, d, o);
    end
    repeat (20) step(0, 0, 0);

    // reset in the middle of a window holding 900
    while (win.size() != 0) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 900, 0);
    repeat (4) step(1, 10, 0);
    rst = 1'b1;
    #1;
    chk_reset();
    model_reset();
    @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    repeat (LC) step(0, 0, 0);
    step(0, 0, 0);
    step(1, 400, 0);
    repeat (WL - 1) step(1, -100, 0);
    repeat (3) step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
